// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV64M multiply/divide engine for the execute stage.
//   Covers MUL/DIV/DIVU/REM/REMU and their *W word forms. A shift-add multiplier
//   and a restoring divider are sequenced by one shared FSM
//   (IDLE -> MUL | DIV | DONE -> DONE -> IDLE).
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, MUL/MULW use a single-cycle '*' product and
//                       complete one cycle after accept. The divider is unchanged.
//                       When undefined, the iterative multiplier is used and no
//                       '*' operator appears in the design.
//
// Parameters:
//   MUL_STEP  multiplier bits retired per cycle (1, 2 or 4)
//   XLEN      datapath width (64 only)
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high; returns to IDLE and clears result
//   valid_i  request present; held stable with operands until done
//   flush    kills any in-flight op; wins over valid_i in IDLE
//   funct3   000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU (others -> result 0)
//   word     1 = 32-bit form, result sign-extended from bit 31
//   src_a    dividend / multiplicand
//   src_b    divisor / multiplier
//   busy     high from the cycle after accept through the done cycle
//   done     one-cycle pulse, result valid
//   result   final value, held until the next done
module muldiv_unit #(
  parameter int MUL_STEP = 1,
  parameter int XLEN     = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int STEP_SH = $clog2(MUL_STEP);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state_q, state_d;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  // Accept-time decode: operand extension, magnitudes, special cases
  logic                   is_mul, is_div, is_uns, accept;
  logic                   a_min, b_neg1, b_zero, ovf, sign_a, sign_b;
  logic signed [XLEN-1:0] ext_a, ext_b;
  logic [XLEN-1:0]        mag_a, mag_b;
  logic [6:0]             w_bits, cnt_load;

  always_comb begin
    is_mul = (funct3 == 3'b000);
    is_div = funct3[2];
    is_uns = is_div & funct3[0];
    accept = (state_q == S_IDLE) & valid_i & ~flush;
    if (word) begin
      ext_a  = is_uns ? {{(XLEN-32){1'b0}}, src_a[31:0]} : sext_word(src_a);
      ext_b  = is_uns ? {{(XLEN-32){1'b0}}, src_b[31:0]} : sext_word(src_b);
      a_min  = (src_a[31:0] == 32'h8000_0000);
      b_neg1 = (src_b[31:0] == 32'hFFFF_FFFF);
      w_bits = 7'd32;
    end else begin
      ext_a  = src_a;
      ext_b  = src_b;
      a_min  = (src_a == {1'b1, {(XLEN-1){1'b0}}});
      b_neg1 = (src_b == {XLEN{1'b1}});
      w_bits = 7'd64;
    end
    b_zero   = (ext_b == '0);
    sign_a   = ~is_uns & ext_a[XLEN-1];
    sign_b   = ~is_uns & ext_b[XLEN-1];
    ovf      = is_div & ~is_uns & a_min & b_neg1;
    mag_a    = cond_neg(ext_a, sign_a);
    mag_b    = cond_neg(ext_b, sign_b);
    cnt_load = (is_mul ? (w_bits >> STEP_SH) : w_bits) - 7'd1;
  end

  // Ops resolved without iterating; their result is written at accept
  logic            spec_hit;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    spec_hit = 1'b0;
    spec_res = '0;
    if (!is_mul && !is_div) begin
      spec_hit = 1'b1;
    end else if (is_div && b_zero) begin
      spec_hit = 1'b1;
      spec_res = funct3[1] ? ext_a : {XLEN{1'b1}};
    end else if (ovf) begin
      spec_hit = 1'b1;
      spec_res = funct3[1] ? '0 : ext_a;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (is_mul) begin
      spec_hit = 1'b1;
      spec_res = ext_a * ext_b;
    end
`endif
    if (word) spec_res = sext_word(spec_res);
  end

  // Iteration registers (data only; control below carries the reset)
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q, quo_q, rem_q, dvsr_q;
  logic [6:0]      cnt_q;
  logic            word_q, want_rem_q, neg_quo_q, neg_rem_q;

  logic [XLEN-1:0] acc_n, mcand_n, mplier_n, quo_n, rem_n;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            fits;
  logic [XLEN-1:0] div_raw, mul_res, div_res;

  always_comb begin
    acc_n    = acc_q;
    mcand_n  = mcand_q;
    mplier_n = mplier_q;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (mplier_n[0]) acc_n = acc_n + mcand_n;
      mcand_n  = mcand_n << 1;
      mplier_n = mplier_n >> 1;
    end
    // Restoring step: the partial remainder stays below the divisor, so one
    // extra bit is enough and the borrow out of it is the compare result.
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, dvsr_q};
    fits     = ~rem_diff[XLEN];
    rem_n    = fits ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_n    = {quo_q[XLEN-2:0], fits};
    div_raw  = want_rem_q ? cond_neg(rem_n, neg_rem_q) : cond_neg(quo_n, neg_quo_q);
    mul_res  = word_q ? sext_word(acc_n) : acc_n;
    div_res  = word_q ? sext_word(div_raw) : div_raw;
  end

  // FSM next state and result write
  logic            res_we;
  logic [XLEN-1:0] res_d;

  always_comb begin
    state_d = state_q;
    res_we  = 1'b0;
    res_d   = spec_res;
    case (state_q)
      S_IDLE: if (accept) begin
        if (spec_hit) begin
          state_d = S_DONE;
          res_we  = 1'b1;
        end else if (is_mul) begin
          state_d = S_MUL;
        end else begin
          state_d = S_DIV;
        end
      end
      S_MUL: if (cnt_q == 7'd0) begin
        state_d = S_DONE;
        res_we  = 1'b1;
        res_d   = mul_res;
      end
      S_DIV: if (cnt_q == 7'd0) begin
        state_d = S_DONE;
        res_we  = 1'b1;
        res_d   = div_res;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flushed op never writes result; a DONE-cycle flush still lets done pulse
    if (flush) begin
      state_d = S_IDLE;
      res_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      result  <= '0;
    end else begin
      state_q <= state_d;
      if (res_we) result <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q      <= '0;
      mcand_q    <= ext_a;
      mplier_q   <= ext_b;
      // Word dividends are pre-shifted so the MSB of the 32-bit value leads
      quo_q      <= word ? (mag_a << 32) : mag_a;
      rem_q      <= '0;
      dvsr_q     <= mag_b;
      cnt_q      <= cnt_load;
      word_q     <= word;
      want_rem_q <= funct3[1];
      neg_quo_q  <= sign_a ^ sign_b;
      neg_rem_q  <= sign_a;
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_n;
      mplier_q <= mplier_n;
      cnt_q    <= cnt_q - 7'd1;
    end else if (state_q == S_DIV) begin
      quo_q <= quo_n;
      rem_q <= rem_n;
      cnt_q <= cnt_q - 7'd1;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Directed operations plus
// randomized operations, each compared against a reference model built from
// plain SystemVerilog arithmetic (/, %, *) and the special-case rules.
module tb_muldiv_unit;

  localparam int MUL_STEP = 1;

  logic        clk = 1'b0;
  logic        reset, valid_i, flush, word;
  logic [2:0]  funct3;
  logic [63:0] src_a, src_b, result;
  logic        busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_STEP(MUL_STEP), .XLEN(64)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush(flush),
    .funct3(funct3), .word(word), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic is_ovf(input logic w, input logic [63:0] a, input logic [63:0] b);
    if (w) return (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    return (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    logic            ovf;
    if (w) begin
      sa = sext32(a);               ua = {32'd0, a[31:0]};
      sb = sext32(b);               ub = {32'd0, b[31:0]};
    end else begin
      sa = a; ua = a;
      sb = b; ub = b;
    end
    ovf = is_ovf(w, a, b);
    case (f3)
      3'b000: r = a * b;
      3'b100: if (sb == 0) r = '1; else if (ovf) r = sa; else r = sa / sb;
      3'b101: if (ub == 0) r = '1; else r = ua / ub;
      3'b110: if (sb == 0) r = sa; else if (ovf) r = '0; else r = sa % sb;
      3'b111: if (ub == 0) r = ua; else r = ua % ub;
      default: return 64'd0;
    endcase
    return w ? sext32(r) : r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    int   width;
    logic bz;
    width = w ? 32 : 64;
    bz    = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    if (f3 == 3'b000) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return width / MUL_STEP + 1;
`endif
    end
    if (!f3[2]) return 1;
    if (bz) return 1;
    if (!f3[0] && is_ovf(w, a, b)) return 1;
    return width + 1;
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
    logic [63:0] exp_res;
    int          exp_lat;
    int          n;
    logic        got;
    exp_res = ref_result(f3, w, a, b);
    exp_lat = ref_latency(f3, w, a, b);
    funct3 = f3; word = w; src_a = a; src_b = b; valid_i = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      step();
      n++;
      if (n == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (done) got = 1'b1;
    end
    valid_i = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    last_res = result;
    step();
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    logic [63:0] prev, a, b;
    logic [2:0]  f3;
    logic        w, saw_done;
    logic [2:0]  ops [10];
    ops = '{3'b000, 3'b000, 3'b100, 3'b101, 3'b110, 3'b111, 3'b100, 3'b110, 3'b001, 3'b011};

    reset = 1'b1; valid_i = 1'b0; flush = 1'b0; funct3 = 3'b000; word = 1'b0;
    src_a = 64'd0; src_b = 64'd0;
    step(); step();
    check("reset_outputs", {result[62:0], busy, done}, 65'd0 >> 1);
    check("reset_result", result, 64'd0);
    reset = 1'b0;
    step();
    check("post_reset_idle", {62'd0, busy, done}, 64'd0);

    do_op(3'b000, 1'b0, 64'd7, -64'sd3, "mul_7_m3");
    check("mul_7_m3_value", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(3'b101, 1'b0, 64'd100, 64'd7, "divu_100_7");
    check("divu_100_7_value", last_res, 64'd14);
    do_op(3'b111, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd7, "remuw");
    check("remuw_value", last_res, 64'd2);
    do_op(3'b100, 1'b0, 64'd42, 64'd0, "div_by_0");
    check("div_by_0_value", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(3'b111, 1'b0, 64'd42, 64'd0, "remu_by_0");
    check("remu_by_0_value", last_res, 64'd42);
    do_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "divw_ovf");
    check("divw_ovf_value", last_res, 64'hFFFF_FFFF_8000_0000);
    do_op(3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "remw_ovf");
    check("remw_ovf_value", last_res, 64'd0);
    do_op(3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, "mulw");
    check("mulw_value", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, "div64_ovf");
    do_op(3'b110, 1'b0, -64'sd100, 64'd7, "rem_neg");
    check("rem_neg_value", last_res, -64'sd2);
    do_op(3'b010, 1'b0, 64'd5, 64'd6, "unsupported");

    // Flush at T+10 of a DIV, then a MUL accepted in the following cycle
    prev = result;
    funct3 = 3'b100; word = 1'b0; src_a = -64'sd100; src_b = 64'd7; valid_i = 1'b1;
    step();
    check("flush_busy_t1", 64'(busy), 64'd1);
    saw_done = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    valid_i = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_no_done", {62'd0, saw_done, done}, 64'd0);
    check("flush_busy_low", 64'(busy), 64'd0);
    check("flush_result_kept", result, prev);
    do_op(3'b000, 1'b0, 64'd3, 64'd5, "mul_after_flush");
    check("mul_after_flush_value", last_res, 64'd15);

    // Flush together with valid in IDLE: nothing accepted
    prev = result;
    funct3 = 3'b101; src_a = 64'd10; src_b = 64'd2; valid_i = 1'b1; flush = 1'b1;
    step();
    valid_i = 1'b0; flush = 1'b0;
    check("flush_valid_idle_busy", 64'(busy), 64'd0);
    step();
    check("flush_valid_idle_done", {62'd0, busy, done}, 64'd0);
    check("flush_valid_idle_result", result, prev);

    // Flush during the done cycle: done still pulses
    funct3 = 3'b100; word = 1'b0; src_a = 64'd9; src_b = 64'd0; valid_i = 1'b1;
    step();
    valid_i = 1'b0; flush = 1'b1;
    #1;
    check("flush_in_done_pulse", 64'(done), 64'd1);
    step();
    flush = 1'b0;
    check("flush_in_done_after", {62'd0, busy, done}, 64'd0);
    check("flush_in_done_result", result, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset part-way through a DIV
    funct3 = 3'b100; word = 1'b0; src_a = 64'd1000; src_b = 64'd3; valid_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    valid_i = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    check("midop_reset_ctrl", {62'd0, busy, done}, 64'd0);
    check("midop_reset_result", result, 64'd0);
    step();
    check("midop_reset_stays_idle", {62'd0, busy, done}, 64'd0);

    // Randomized operations with bias toward the special cases
    for (int i = 0; i < 40; i++) begin
      f3 = ops[$urandom_range(0, 9)];
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = {$urandom, 32'd0} & (w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
        1: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        2: b = 64'($urandom_range(1, 15));
        3: b = -64'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(f3, w, a, b, $sformatf("rnd%0d_f%0d_w%0d", i, f3, w));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
